sha_1_padder: RTL and testbench

Message-side front end for the SHA-1 core. Accepts an arbitrary-length byte stream and applies SHA-1 padding: append 0x80, zero-fill, then append the 64-bit big-endian bit length. Delivers complete 512-bit blocks as sixteen 32-bit words in the core's data[15:0] format, with first/last flags so the downstream hash engine knows when to load the initial H values and when to finalise.

---
 rtl/sha_1_padder.sv | 142 ++++++++++++++
 tb/tb_sha_1_padder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sha_1_padder.sv
// SHA-1 message padder: byte stream in, padded 512-bit blocks out as sixteen
// big-endian 32-bit words with first/last flags for the hash core.
module sha_1_padder #(
   parameter int unsigned LEN_W = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_data,
   input  logic              in_keep,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [15:0][31:0] q_block,
   output logic              out_first,
   output logic              out_last
);

   typedef enum logic [2:0] {S_FILL, S_PAD80, S_ZERO, S_LEN, S_EMIT} state_t;

   state_t            r_state, r_pend;
   logic [6:0]        r_idx;
   logic [LEN_W-1:0]  r_len;
   logic              r_first_pend, r_final, r_fits;
   logic [15:0][31:0] r_block;
   logic              r_out_valid, r_out_first, r_out_last;

   logic              w_accept;
   logic [3:0]        w_word;
   logic [4:0]        w_lane;
   logic [6:0]        w_idx_inc;
   logic [63:0]       w_len64;

   assign w_accept  = in_valid && (r_state == S_FILL);
   assign w_word    = r_idx[5:2];
   assign w_lane    = {~r_idx[1:0], 3'b000};
   assign w_idx_inc = r_idx + 7'd1;
   assign w_len64   = 64'(r_len);

   assign in_ready  = (r_state == S_FILL);
   assign out_valid = r_out_valid;
   assign out_first = r_out_first;
   assign out_last  = r_out_last;
   assign q_block   = r_block;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_FILL;
         r_pend       <= S_FILL;
         r_idx        <= '0;
         r_len        <= '0;
         r_first_pend <= 1'b1;
         r_final      <= 1'b0;
         r_fits       <= 1'b1;
         r_block      <= '0;
         r_out_valid  <= 1'b0;
         r_out_first  <= 1'b0;
         r_out_last   <= 1'b0;
      end else begin
         case (r_state)
            S_FILL: begin
               if (w_accept) begin
                  if (in_keep) begin
                     r_block[w_word][w_lane +: 8] <= in_data;
                     r_idx <= w_idx_inc;
                     r_len <= r_len + LEN_W'(8);
                  end
                  if (in_keep && r_idx == 7'd63) begin
                     r_state     <= S_EMIT;
                     r_pend      <= in_last ? S_PAD80 : S_FILL;
                     r_out_valid <= 1'b1;
                     r_out_first <= r_first_pend;
                     r_out_last  <= 1'b0;
                  end else if (in_last) begin
                     r_state <= S_PAD80;
                  end
               end
            end
            S_PAD80: begin
               r_block[w_word][w_lane +: 8] <= 8'h80;
               r_idx <= w_idx_inc;
               // r_fits: the length field still fits in this block after the 0x80
               if (r_idx == 7'd63) begin
                  r_fits      <= 1'b1;
                  r_state     <= S_EMIT;
                  r_pend      <= S_ZERO;
                  r_out_valid <= 1'b1;
                  r_out_first <= r_first_pend;
                  r_out_last  <= 1'b0;
               end else begin
                  r_fits  <= (r_idx <= 7'd55);
                  r_state <= S_ZERO;
               end
            end
            S_ZERO: begin
               if (r_fits && r_idx == 7'd56) begin
                  r_state <= S_LEN;
               end else if (r_idx == 7'd64) begin
                  r_fits      <= 1'b1;
                  r_state     <= S_EMIT;
                  r_pend      <= S_ZERO;
                  r_out_valid <= 1'b1;
                  r_out_first <= r_first_pend;
                  r_out_last  <= 1'b0;
               end else begin
                  r_block[w_word][w_lane +: 8] <= 8'h00;
                  r_idx <= w_idx_inc;
               end
            end
            S_LEN: begin
               r_block[14]  <= w_len64[63:32];
               r_block[15]  <= w_len64[31:0];
               r_final      <= 1'b1;
               r_state      <= S_EMIT;
               r_out_valid  <= 1'b1;
               r_out_first  <= r_first_pend;
               r_out_last   <= 1'b1;
            end
            S_EMIT: begin
               if (out_ready) begin
                  r_out_valid  <= 1'b0;
                  r_out_first  <= 1'b0;
                  r_out_last   <= 1'b0;
                  r_idx        <= '0;
                  r_first_pend <= 1'b0;
                  if (r_final) begin
                     r_len        <= '0;
                     r_first_pend <= 1'b1;
                     r_final      <= 1'b0;
                     r_state      <= S_FILL;
                  end else begin
                     r_state <= r_pend;
                  end
               end
            end
            default: r_state <= S_FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_sha_1_padder.sv
// Bench for sha_1_padder: directed and random messages checked against a
// queue-based SHA-1 padding model.
module tb_sha_1_padder;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid, in_ready, in_keep, in_last;
   logic [7:0]        in_data;
   logic              out_valid, out_ready, out_first, out_last;
   logic [15:0][31:0] q_block;

   int checks = 0;
   int failures = 0;
   logic [511:0] exp_q[$];

   always #5 clk = ~clk;

   sha_1_padder #(.LEN_W(64)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_keep(in_keep), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .q_block(q_block),
      .out_first(out_first), .out_last(out_last)
   );

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Padded message = msg, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length.
   function automatic void model(input logic [7:0] msg[$]);
      logic [7:0]  p[$];
      logic [63:0] bl;
      logic [511:0] blk;
      p  = msg;
      bl = 64'(msg.size()) * 64'd8;
      p.push_back(8'h80);
      while (p.size() % 64 != 56) p.push_back(8'h00);
      for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
      exp_q.delete();
      for (int b = 0; b < p.size() / 64; b++) begin
         blk = '0;
         for (int w = 0; w < 16; w++)
            blk[32*w +: 32] = {p[64*b+4*w], p[64*b+4*w+1], p[64*b+4*w+2], p[64*b+4*w+3]};
         exp_q.push_back(blk);
      end
   endfunction

   task automatic run_msg(input logic [7:0] msg[$], input bit sep_term, input int gap_pct,
                          input int stall, input int exp_lat);
      int pos = 0;
      int nblk = 0;
      int cyc = 0;
      int acc_cyc = -1;
      bit lat_done = 1'b0;
      int nbeats;
      int stall_left;
      int nexp;
      model(msg);
      nexp       = exp_q.size();
      nbeats     = msg.size() + ((sep_term || msg.size() == 0) ? 1 : 0);
      stall_left = stall;
      while (nblk < nexp && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         out_ready = 1'b0;
         if (out_valid) begin
            if (exp_lat >= 0 && !lat_done) begin
               lat_done = 1'b1;
               chk("latency", 512'(cyc - acc_cyc), 512'(exp_lat));
            end
            chk("block", q_block, exp_q[nblk]);
            chk("out_first", 512'(out_first), 512'(nblk == 0));
            chk("out_last", 512'(out_last), 512'(nblk == nexp - 1));
            chk("in_ready_emit", 512'(in_ready), 512'(0));
            if (stall_left > 0) stall_left--;
            else if (int'($urandom_range(99)) >= gap_pct) begin
               out_ready = 1'b1;
               nblk++;
            end
         end
         in_valid = 1'b0;
         in_keep  = 1'b0;
         in_last  = 1'b0;
         in_data  = 8'($urandom);
         if (pos < nbeats) begin
            if (int'($urandom_range(99)) < gap_pct) begin
               if ($urandom_range(3) == 0) in_valid = 1'b1;
            end else begin
               in_valid = 1'b1;
               if (pos < msg.size()) begin
                  in_keep = 1'b1;
                  in_data = msg[pos];
               end
               in_last = (pos == nbeats - 1);
               if (in_ready) begin
                  pos++;
                  if (pos == nbeats) acc_cyc = cyc;
               end
            end
         end
      end
      chk("blocks_done", 512'(nblk), 512'(nexp));
   endtask

   initial begin
      logic [7:0] m[$];
      reset = 1'b1; in_valid = 1'b0; in_keep = 1'b0; in_last = 1'b0;
      in_data = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_block", q_block, '0);
      chk("rst_valid", 512'(out_valid), 512'(0));
      chk("rst_first", 512'(out_first), 512'(0));
      chk("rst_last", 512'(out_last), 512'(0));
      chk("rst_in_ready", 512'(in_ready), 512'(1));
      reset = 1'b0;

      m = {8'h61, 8'h62, 8'h63};
      run_msg(m, 1'b0, 0, 0, 56);
      chk("abc_word0", 512'(exp_q[0][31:0]), 512'(32'h61626380));
      chk("abc_word15", 512'(exp_q[0][511:480]), 512'(32'h00000018));

      m.delete();
      run_msg(m, 1'b1, 0, 0, -1);
      chk("empty_word0", 512'(exp_q[0][31:0]), 512'(32'h80000000));

      m.delete(); repeat (55) m.push_back(8'h41);
      run_msg(m, 1'b0, 0, 0, -1);
      chk("b55_word13", 512'(exp_q[0][447:416]), 512'(32'h41414180));
      chk("b55_word15", 512'(exp_q[0][511:480]), 512'(32'h000001B8));

      m.delete(); repeat (56) m.push_back(8'h41);
      run_msg(m, 1'b0, 0, 10, -1);
      chk("b56_nblocks", 512'(exp_q.size()), 512'(2));

      m.delete(); repeat (64) m.push_back(8'h00);
      run_msg(m, 1'b0, 0, 0, -1);
      chk("b64_blockB_word15", 512'(exp_q[1][511:480]), 512'(32'h00000200));
      run_msg(m, 1'b1, 20, 0, -1);

      m.delete(); repeat (60) m.push_back(8'($urandom));
      run_msg(m, 1'b1, 25, 2, -1);

      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         in_valid = 1'b1; in_keep = 1'b1; in_last = 1'b0; in_data = 8'($urandom);
      end
      @(negedge clk);
      in_valid = 1'b0; in_keep = 1'b0;
      reset = 1'b1;
      #1;
      chk("mid_rst_block", q_block, '0);
      chk("mid_rst_valid", 512'(out_valid), 512'(0));
      chk("mid_rst_first", 512'(out_first), 512'(0));
      chk("mid_rst_last", 512'(out_last), 512'(0));
      chk("mid_rst_in_ready", 512'(in_ready), 512'(1));
      @(negedge clk);
      reset = 1'b0;
      m = {8'h61, 8'h62, 8'h63};
      run_msg(m, 1'b0, 0, 0, 56);

      for (int r = 0; r < 8; r++) begin
         int unsigned len;
         len = $urandom_range(150);
         m.delete();
         for (int unsigned j = 0; j < len; j++) m.push_back(8'($urandom));
         run_msg(m, 1'($urandom_range(1)), 30, int'($urandom_range(3)), -1);
      end

      @(negedge clk);
      out_ready = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
